// File: rtl/biu_pkg.sv
// Shared types and constants for the BIU responder: FSM states, dispatch select codes
// and instruction-word field positions.
package biu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWb,
    StMem,
    StDone
  } biu_state_e;

  localparam logic [1:0] SEL_MOV = 2'b00;
  localparam logic [1:0] SEL_LST = 2'b01;

  localparam int unsigned RD_HI       = 15;
  localparam int unsigned RD_LO       = 12;
  localparam int unsigned RS_HI       = 11;
  localparam int unsigned RS_LO       = 8;
  localparam int unsigned IMM_HI      = 7;
  localparam int unsigned IMM_LO      = 0;
  localparam int unsigned MOV_IMM_BIT = 19;
  localparam int unsigned ST_BIT      = 18;

endpackage

// File: rtl/biu_wdt.sv
// Memory-ack watchdog: loadable down-counter whose expire flag marks the last allowed
// waiting cycle.
module biu_wdt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic dec,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CW'(TIMEOUT);
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  // A count of one means this is the TIMEOUT-th cycle spent waiting.
  assign expire = (count_q == CW'(1));

endmodule

// File: rtl/biu_responder.sv
// BIU endpoint: executes MOV and load/store requests from the decoder and signals
// completion on ready_bus with registered outputs.
module biu_responder
  import biu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_biu,
  input  logic [1:0]        sel_biu,
  input  logic [31:0]       ir,
  output logic              ready_bus,
  output logic              err,
  output logic [3:0]        ra_addr,
  input  logic [DATA_W-1:0] ra_data,
  output logic [3:0]        rb_addr,
  input  logic [DATA_W-1:0] rb_data,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  biu_state_e state_q, state_d;
  logic       st_q;
  logic       cs_act, accept;
  logic       wdt_load, wdt_clr, wdt_dec, wdt_expire, timeout;
  logic [7:0] imm8;
  logic       unused_ir;

  // Only a driven 1 counts; X/Z from an undriven select falls through as inactive.
  assign cs_act    = (cs_biu == 1'b1);
  assign accept    = (state_q == StIdle) && cs_act;
  assign imm8      = ir[IMM_HI:IMM_LO];
  assign ra_addr   = ir[RS_HI:RS_LO];
  assign rb_addr   = ir[RD_HI:RD_LO];
  assign unused_ir = ^{ir[31:20], ir[17:16]};

  biu_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wdt_load),
    .clr    (wdt_clr),
    .dec    (wdt_dec),
    .expire (wdt_expire)
  );

  always_comb begin
    state_d  = state_q;
    wdt_load = 1'b0;
    wdt_clr  = 1'b0;
    wdt_dec  = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cs_act) begin
          if (sel_biu == SEL_MOV) begin
            state_d = StWb;
          end else if (sel_biu == SEL_LST) begin
            state_d  = StMem;
            wdt_load = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StWb: state_d = StDone;
      StMem: begin
        // An ack on the final watchdog cycle still completes the access.
        if (mem_ack) begin
          wdt_clr = 1'b1;
          state_d = st_q ? StDone : StWb;
        end else if (wdt_expire) begin
          wdt_clr = 1'b1;
          timeout = 1'b1;
          state_d = StDone;
        end else begin
          wdt_dec = 1'b1;
        end
      end
      StDone: begin
        if (!cs_act) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      st_q      <= 1'b0;
      ready_bus <= 1'b0;
      err       <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      ready_bus <= (state_d == StDone);
      wr_en     <= (state_d == StWb);
      mem_req   <= (state_d == StMem);
      if (accept) begin
        err     <= (sel_biu != SEL_MOV) && (sel_biu != SEL_LST);
        wr_addr <= ir[RD_HI:RD_LO];
        st_q    <= ir[ST_BIT];
        if (sel_biu == SEL_MOV) begin
          wr_data <= ir[MOV_IMM_BIT] ? DATA_W'(imm8) : ra_data;
        end
        if (sel_biu == SEL_LST) begin
          mem_addr  <= ra_data[ADDR_W-1:0] + ADDR_W'(imm8);
          mem_we    <= ir[ST_BIT];
          mem_wdata <= rb_data;
        end
      end
      if ((state_q == StMem) && mem_ack && !st_q) begin
        wr_data <= mem_rdata;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_biu_responder.sv
// Directed bench for biu_responder: a negedge monitor pops expected register writes and
// completions from scoreboard queues filled as each request is issued.
module tb_biu_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_biu;
  logic [1:0]  sel_biu;
  logic [31:0] ir;
  logic        ready_bus, err;
  logic [3:0]  ra_addr, rb_addr, wr_addr;
  logic [31:0] ra_data, rb_data, wr_data, mem_wdata, mem_rdata;
  logic        wr_en, mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          lat;
  } wr_exp_t;

  typedef struct {
    logic err;
    int   lat;
  } done_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int reqcnt   = 0;
  logic ready_prev = 1'b0;

  biu_responder #(
    .DATA_W (32),
    .ADDR_W (16),
    .TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_biu    (cs_biu),
    .sel_biu   (sel_biu),
    .ir        (ir),
    .ready_bus (ready_bus),
    .err       (err),
    .ra_addr   (ra_addr),
    .ra_data   (ra_data),
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe and every ready rising edge must be expected.
  always begin
    @(negedge clk);
    if (rst_n) begin
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 64'd1, 64'd0);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(wr_data), 64'(e.data));
          check("wr_lat", 64'(cyc - t0), 64'(e.lat));
        end
      end
      if (ready_bus && !ready_prev) begin
        if (done_q.size() == 0) begin
          check("ready_unexpected", 64'd1, 64'd0);
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          check("done_err", 64'(err), 64'(d.err));
          check("done_lat", 64'(cyc - t0), 64'(d.lat));
        end
      end
      if (mem_req) reqcnt++;
    end
    ready_prev = ready_bus;
  end

  task automatic issue(input logic [1:0] sel, input logic [31:0] iw, input logic [31:0] ra,
                       input logic [31:0] rb);
    @(posedge clk);
    #1;
    cs_biu  = 1'b1;
    sel_biu = sel;
    ir      = iw;
    ra_data = ra;
    rb_data = rb;
    t0      = cyc;
    reqcnt  = 0;
  endtask

  task automatic wait_ready(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ready_bus) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ready_wait", 64'd0, 64'd1);
  endtask

  task automatic end_op();
    @(posedge clk);
    #1;
    cs_biu = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ready_drop", 64'(ready_bus), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n     = 1'b0;
    cs_biu    = 1'b0;
    sel_biu   = 2'b00;
    ir        = '0;
    ra_data   = '0;
    rb_data   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #3;
    check("rst_ctrl", 64'({ready_bus, err, wr_en, mem_req, mem_we}), 64'd0);
    check("rst_wr", 64'({wr_addr, wr_data}), 64'd0);
    check("rst_mem", 64'({mem_addr, mem_wdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MOV immediate: rd=3, rs=7, imm8=A5
    issue(2'b00, 32'h0008_37A5, 32'h1111_1111, 32'h2222_2222);
    wr_q.push_back('{addr: 4'h3, data: 32'h0000_00A5, lat: 1});
    done_q.push_back('{err: 1'b0, lat: 2});
    #1;
    check("ra_addr", 64'(ra_addr), 64'h7);
    check("rb_addr", 64'(rb_addr), 64'h3);
    wait_ready(10);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_hold1", 64'(ready_bus), 64'd1);
    @(posedge clk);
    #1;
    cs_biu = 1'b0;
    @(negedge clk);
    check("ready_hold2", 64'(ready_bus), 64'd1);
    @(negedge clk);
    check("ready_release", 64'(ready_bus), 64'd0);
    check("mov_no_req", 64'(reqcnt), 64'd0);

    // Load with wrapping address, ack on the third cycle after the first request cycle
    issue(2'b01, 32'h0000_5220, 32'h0000_FFF0, 32'h0);
    wr_q.push_back('{addr: 4'h5, data: 32'hDEAD_BEEF, lat: 5});
    done_q.push_back('{err: 1'b0, lat: 6});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ld_req", 64'(mem_req), 64'd1);
    check("ld_addr", 64'(mem_addr), 64'h0010);
    check("ld_we", 64'(mem_we), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("ld_req_drop", 64'(mem_req), 64'd0);
    wait_ready(10);
    check("ld_req_cycles", 64'(reqcnt), 64'd4);
    end_op();

    // Store, cs_biu dropped mid-operation so ready pulses for a single cycle
    issue(2'b01, 32'h0004_9404, 32'h0000_0100, 32'h1234_5678);
    done_q.push_back('{err: 1'b0, lat: 3});
    @(posedge clk);
    #1;
    cs_biu = 1'b0;
    @(negedge clk);
    check("st_we", 64'(mem_we), 64'd1);
    check("st_wdata", 64'(mem_wdata), 64'h1234_5678);
    check("st_addr", 64'(mem_addr), 64'h0104);
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    wait_ready(10);
    @(negedge clk);
    check("st_ready_pulse", 64'(ready_bus), 64'd0);
    check("st_req_cycles", 64'(reqcnt), 64'd2);

    // Timeout: never acknowledged
    issue(2'b01, 32'h0000_6300, 32'h0000_0040, 32'h0);
    done_q.push_back('{err: 1'b1, lat: 5});
    wait_ready(20);
    check("to_req_cycles", 64'(reqcnt), 64'd4);
    check("to_err", 64'(err), 64'd1);
    check("to_req_low", 64'(mem_req), 64'd0);
    end_op();

    // MOV register form after the timeout clears err
    issue(2'b00, 32'h0000_1200, 32'hCAFE_F00D, 32'h0);
    wr_q.push_back('{addr: 4'h1, data: 32'hCAFE_F00D, lat: 1});
    done_q.push_back('{err: 1'b0, lat: 2});
    wait_ready(10);
    check("mov_err_clear", 64'(err), 64'd0);
    end_op();

    // Illegal selects
    issue(2'b10, 32'h0000_1234, 32'h0, 32'h0);
    done_q.push_back('{err: 1'b1, lat: 1});
    wait_ready(10);
    check("ill10_no_req", 64'(reqcnt), 64'd0);
    end_op();
    issue(2'b11, 32'h0008_4321, 32'h0, 32'h0);
    done_q.push_back('{err: 1'b1, lat: 1});
    wait_ready(10);
    check("ill11_err", 64'(err), 64'd1);
    end_op();

    // Asynchronous reset while a load is outstanding, then a late ack
    issue(2'b01, 32'h0000_2008, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_pre_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_req_drop", 64'(mem_req), 64'd0);
    cs_biu = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_ignored", 64'({mem_req, wr_en, ready_bus}), 64'd0);

    issue(2'b00, 32'h0008_E05A, 32'h0, 32'h0);
    wr_q.push_back('{addr: 4'hE, data: 32'h0000_005A, lat: 1});
    done_q.push_back('{err: 1'b0, lat: 2});
    wait_ready(10);
    end_op();

    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/biu_responder.md
Name: biu_responder

Overview:
- Bus interface unit endpoint for the instruction decoder's BIU dispatch path.
- Accepts a request on `cs_biu`/`sel_biu`, with `ir` held stable by the decoder, and executes it:
  - register move (MOV), or
  - memory load/store (L_ST) over a req/ack memory port with a watchdog.
- Returns completion to the decoder on `ready_bus`; writes load and move results to the register file write port.

Parameters:
- DATA_W, 32, register and memory data width.
- ADDR_W, 16, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- TIMEOUT, 255, max cycles waiting for `mem_ack` before abort (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs_biu  in  1  request select from decoder; only a 1 counts as active, 0 and Z are treated as inactive.
- sel_biu  in  2  operation: 00 MOV, 01 L_ST, 1x illegal.
- ir  in  32  instruction word, stable while cs_biu=1.
- ready_bus  out  1  completion to decoder.
- err  out  1  completion status; valid while ready_bus=1.
- ra_addr  out  4  register read port A address = ir[11:8] (rs), combinational.
- ra_data  in  DATA_W  read data A.
- rb_addr  out  4  register read port B address = ir[15:12] (rd), combinational.
- rb_data  in  DATA_W  read data B (store data).
- wr_en  out  1  register write strobe, one cycle.
- wr_addr  out  4  register write address.
- wr_data  out  DATA_W  register write data.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- mem_ack  in  1  memory acknowledge, one cycle.

Behaviour:
- Reset: state IDLE. ready_bus, err, wr_en, mem_req and mem_we are 0. wr_addr, wr_data, mem_addr, mem_wdata and the watchdog count are 0. All outputs are registered.
- Reset mid-operation drops mem_req immediately; a pending ack after reset is ignored.
- IR fields:
  - rd = ir[15:12], rs = ir[11:8], imm8 = ir[7:0].
  - MOV form: ir[19] = 0 register, 1 immediate.
  - L_ST form: ir[18] = 0 load, 1 store.
- IDLE: when cs_biu==1, accept (cycle T0):
  - latch rd, imm8, ir[19], ir[18], ra_data, rb_data;
  - clear err;
  - go to WB (MOV), MEM (L_ST), or DONE with err=1 (illegal).
- MOV:
  - WB at T1: wr_en=1, wr_addr=rd, wr_data = zero-extended imm8 (ir[19]=1) or latched ra_data (ir[19]=0).
  - DONE at T2.
- MEM:
  - mem_req=1 from T1.
  - mem_addr = latched ra_data[ADDR_W-1:0] + zero-extended imm8, wrapping.
  - mem_we = ir[18]; mem_wdata = latched rb_data.
  - Address, we and wdata are stable while mem_req=1.
  - On mem_ack: mem_req=0 next cycle. Load: capture mem_rdata, go to WB (wr_addr=rd, wr_data=captured). Store: go to DONE.
  - Watchdog counts cycles with mem_req=1 and no ack. On reaching TIMEOUT without ack: mem_req=0, err=1, DONE, no register write.
  - mem_ack while not in MEM is ignored.
- Latency from accept to ready_bus:
  - MOV: 2 cycles.
  - Load with ack at cycle T1+k: k+3 cycles.
  - Store with ack at cycle T1+k: k+2 cycles.
  - Illegal: 1 cycle.
- DONE: ready_bus=1, held while cs_biu==1, so the decoder's two-stage ready sampling both see it. When cs_biu!=1: ready_bus=0 the next cycle and return to IDLE.
  - If cs_biu has already dropped on entering DONE, ready_bus pulses exactly one cycle.
- Back-to-back requests: a new request is accepted only from IDLE. cs_biu must be observed !=1 for at least one cycle between operations; the decoder guarantees this through its idle/decode states.
- cs_biu dropping mid-operation does not abort; the operation completes.
- Exactly one wr_en pulse per MOV or successful load; none for store, timeout or illegal.

Decomposition:
- Package biu_pkg holds:
  - state enum (IDLE, WB, MEM, DONE);
  - sel_biu codes SEL_MOV=2'b00, SEL_LST=2'b01;
  - IR field bit positions (RD_HI/LO, RS_HI/LO, IMM_HI/LO, MOV_IMM_BIT=19, ST_BIT=18).
- One sub-module, biu_wdt: a loadable down-counter with clear and expire outputs, parameterised by TIMEOUT.

Test Plan:
- MOV immediate: sel=00, ir[19]=1, rd=3, imm8=0xA5 → wr_en at T1 with wr_addr=3, wr_data=0x000000A5; ready_bus=1 at T2; held until cs_biu=Z, then 0 the next cycle.
- Load: ra_data=0x0000FFF0, imm8=0x20, ir[18]=0, ack after 3 cycles with rdata=0xDEADBEEF → mem_addr=0x0010 (wrap), mem_we=0; wr_data=0xDEADBEEF; ready_bus 6 cycles after accept; err=0.
- Store: rb_data=0x12345678, ack after 1 cycle → mem_we=1, mem_wdata=0x12345678, no wr_en, ready_bus 3 cycles after accept.
- Timeout: TIMEOUT=4, never ack → mem_req high exactly 4 cycles, then err=1 and ready_bus=1, no wr_en; next MOV clears err.
- Illegal sel=10 → ready_bus=1 and err=1 one cycle after accept, mem_req and wr_en never asserted.
- Async reset: rst_n low during MEM → mem_req=0 immediately; a late ack is ignored; a new request afterwards completes normally.
